logic_unit_arbiter: RTL
=======================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CNTW, default 8, width of per-requester grant counters.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 req1_valid, req1_a, req1_b, req1_op, req1_ready  same widths/meaning for requester 1.
REQ-010 rsp_valid  output  1  result register holds an undelivered result.
REQ-011 rsp_id  output  1  requester that issued the held result.
REQ-012 rsp_result  output  WIDTH  held result.
REQ-013 rsp_ready  input  1  consumer takes the result this cycle.
REQ-014 grant_cnt0, grant_cnt1  output  CNTW each  accepted-operation counts per requester.

Function
REQ-015 Transfer on a request port SHALL occur in any cycle where reqN_valid and reqN_ready are both 1 at the rising edge.
REQ-016 Slot free = (rsp_valid == 0) or (rsp_ready == 1); reqN_ready SHALL be 0 whenever the slot is not free.
REQ-017 Slot free with only one valid requester: that requester's ready SHALL be 1.
REQ-018 Slot free with both valid: grant SHALL go to the requester not in last_grant (round-robin); the other's ready SHALL be 0.
REQ-019 reqN_ready SHALL be combinational from valids, last_grant, rsp_valid, rsp_ready; it SHALL never depend on operand or opcode values.
REQ-020 On transfer, last_grant SHALL update to the granted id at that edge.
REQ-021 On transfer, rsp_result SHALL load the bitwise op of the granted operands, all WIDTH bits, no carries.
REQ-022 On transfer, rsp_id SHALL load the granted id and rsp_valid SHALL be 1 from the next cycle (latency 1 cycle).
REQ-023 Consumer draining (rsp_valid & rsp_ready) with no new transfer SHALL clear rsp_valid at that edge.
REQ-024 Simultaneous drain and transfer SHALL replace the held result with no bubble; rsp_valid stays 1.
REQ-025 While rsp_valid=1 and rsp_ready=0, rsp_result and rsp_id SHALL hold stable.
REQ-026 Deasserting reqN_valid without a transfer SHALL leave last_grant unchanged; no state change.
REQ-027 grant_cntN SHALL increment by 1 per transfer from requester N, wrapping from 2^CNTW-1 to 0.
REQ-028 States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1). EMPTY->FULL on transfer; FULL->EMPTY on drain without transfer; FULL->FULL on hold or drain+transfer.

Reset
REQ-029 While reset=1, regardless of clock: rsp_valid=0, rsp_id=0, rsp_result=0, grant_cnt0=0, grant_cnt1=0, last_grant=1 so requester 0 wins the first contention.
REQ-030 Reset asserted mid-operation SHALL discard any held result; no response SHALL appear after reset deasserts.
REQ-031 reqN_ready SHALL be 0 while reset=1.

Verification
REQ-032 After reset, both valid, req0 OR 0x0000_00F0|0x0000_000F, req1 AND 0xFFFF_0000&0x0F0F_0F0F, rsp_ready=1 -> cycle 1 rsp_id=0 result 0x0000_00FF; cycle 2 rsp_id=1 result 0x0F0F_0000; grant_cnt0=1, grant_cnt1=1.
REQ-033 Both requesters held valid 6 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1; each counter ends at 3.
REQ-034 One transfer req0 XOR 0xAAAA_AAAA^0xFFFF_FFFF, rsp_ready=0 for 4 cycles -> rsp_valid=1, result 0x5555_5555 stable, both ready=0; rsp_ready=1 -> drain, readies reassert.
REQ-035 rsp_valid=1, rsp_ready=1, req1 NOR 0x0^0x0 valid same cycle -> next cycle rsp_valid=1, rsp_id=1, result 0xFFFF_FFFF, no empty cycle.
REQ-036 Only req0 valid for 256 transfers with CNTW=8 -> grant_cnt0 wraps to 0, grant_cnt1=0.
REQ-037 Reset asserted asynchronously while FULL -> rsp_valid drops before next edge; no response after release until a new transfer.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter feeding a bitwise logic unit with one
// response slot and grant counters.
// Ports: clock/reset; req0_*/req1_* valid-ready requests carrying operands
// and opcode; rsp_* valid-ready response; grant_cnt0/1 accepted-op counts.
module logic_unit_arbiter #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   input  logic             rsp_ready,
   output logic [CNTW-1:0]  grant_cnt0,
   output logic [CNTW-1:0]  grant_cnt1
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [CNTW-1:0]  cnt0_q, cnt0_d;
   logic [CNTW-1:0]  cnt1_q, cnt1_d;

   logic             slot_free;
   logic             gnt0, gnt1, xfer;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] op_res;

   // Slot can take a new result if empty or being drained this cycle.
   assign slot_free = (state_q == EMPTY) | rsp_ready;

   // last_grant_q = 1 means requester 1 won last, so 0 wins a tie.
   assign gnt0 = ~reset & slot_free & req0_valid
                 & (~req1_valid | last_grant_q);
   assign gnt1 = ~reset & slot_free & req1_valid
                 & (~req0_valid | ~last_grant_q);
   assign xfer = gnt0 | gnt1;

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign sel_a  = gnt1 ? req1_a  : req0_a;
   assign sel_b  = gnt1 ? req1_b  : req0_b;
   assign sel_op = gnt1 ? req1_op : req0_op;

   always_comb begin
      op_res = '0;
      unique case (sel_op)
         2'b00: op_res = sel_a & sel_b;
         2'b01: op_res = sel_a | sel_b;
         2'b10: op_res = sel_a ^ sel_b;
         2'b11: op_res = ~(sel_a | sel_b);
         default: op_res = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      if (xfer) begin
         // Covers drain+transfer too: the slot is refilled with no bubble.
         state_d      = FULL;
         last_grant_d = gnt1;
         rsp_id_d     = gnt1;
         rsp_result_d = op_res;
         if (gnt0) cnt0_d = cnt0_q + CNTW'(1);
         if (gnt1) cnt1_d = cnt1_q + CNTW'(1);
      end else if ((state_q == FULL) && rsp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= EMPTY;
         last_grant_q <= 1'b1;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   assign rsp_valid  = (state_q == FULL);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;

endmodule
